bp_fe_queue_ckpt: RTL and testbench

- Checkpointing instruction queue between the front end and the back-end scheduler; upstream neighbour of the back end.
- Buffers fetch packets from the FE and presents them speculatively to the issue stage.
- Retains each issued entry until the back end commits it (deq), discards it with everything younger (clr), or replays from the oldest uncommitted entry (roll).

---
 rtl/bp_fe_queue_ckpt.sv | 87 ++++++++
 tb/tb_bp_fe_queue_ckpt.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_queue_ckpt.sv
// Checkpointing FE instruction queue: speculative issue with commit, rollback and flush.
// Three wrap-bit pointers: wptr (write), rptr (speculative read), cptr (commit).
module bp_fe_queue_ckpt #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned width_p = 128,
  localparam int unsigned ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [width_p-1:0]      fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    fe_queue_deq_i,
  input  logic                    fe_queue_roll_i,
  input  logic                    fe_queue_clr_i,
  output logic [ptr_width_lp-1:0] occupancy_o
);

  localparam int unsigned idx_width_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] full_cnt_lp = ptr_width_lp'(els_p);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [width_p-1:0]      mem_q [els_p];

  logic full;
  logic enq;

  // Status derived purely from pointer state (and clr for ready)
  always_comb begin
    occupancy_o      = wptr_q - cptr_q;
    full             = (occupancy_o == full_cnt_lp);
    fe_queue_ready_o = ~full & ~fe_queue_clr_i;
    fe_queue_v_o     = (rptr_q != wptr_q);
    fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];
    enq              = fe_queue_v_i & fe_queue_ready_o;
  end

  // Pointer next-state: commit first, then clr > roll > normal issue
  always_comb begin
    cptr_d = cptr_q + ptr_width_lp'(fe_queue_deq_i);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (fe_queue_clr_i) begin
      rptr_d = cptr_d;
      wptr_d = cptr_d;
    end else begin
      if (fe_queue_roll_i) begin
        rptr_d = cptr_d;
      end else begin
        rptr_d = rptr_q + ptr_width_lp'(fe_queue_yumi_i);
      end
      wptr_d = wptr_q + ptr_width_lp'(enq);
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Packet storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
    end
  end

  // Protocol checks on the back-end handshakes
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_deq_i |-> (cptr_q != rptr_q));

endmodule

// File: tb/tb_bp_fe_queue_ckpt.sv
// Bench for bp_fe_queue_ckpt: directed stimulus, queue-level reference model, per-cycle compare.
module tb_bp_fe_queue_ckpt;

  localparam int unsigned ELS = 8;
  localparam int unsigned W   = 128;
  localparam int unsigned PW  = 4;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  fe_queue_i;
  logic          fe_queue_v_i;
  logic          fe_queue_ready_o;
  logic [W-1:0]  fe_queue_o;
  logic          fe_queue_v_o;
  logic          fe_queue_yumi_i;
  logic          fe_queue_deq_i;
  logic          fe_queue_roll_i;
  logic          fe_queue_clr_i;
  logic [PW-1:0] occupancy_o;

  int n_checks = 0;
  int n_fail   = 0;

  bp_fe_queue_ckpt #(.els_p(ELS), .width_p(W)) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_clr_i   (fe_queue_clr_i),
    .occupancy_o      (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries from the commit point onward, plus how many are issued
  logic [W-1:0] mq[$];
  int rd   = 0;
  int cabs = 0;

  task automatic model_clear();
    mq.delete();
    rd   = 0;
    cabs = 0;
  endtask

  task automatic model_compare();
    logic [PW-1:0] exp_w;
    exp_w = PW'((cabs + mq.size()) % 16);
    chk("m_ready", W'(fe_queue_ready_o), W'((mq.size() < ELS) && !fe_queue_clr_i));
    chk("m_valid", W'(fe_queue_v_o), W'(rd < mq.size()));
    chk("m_occ", W'(occupancy_o), W'(mq.size()));
    chk("m_wptr", W'(dut.wptr_q), W'(exp_w));
    if (rd < mq.size()) chk("m_data", fe_queue_o, mq[rd]);
  endtask

  task automatic model_update();
    bit ready;
    bit enq;
    ready = (mq.size() < ELS) && !fe_queue_clr_i;
    enq   = fe_queue_v_i && ready;
    if (fe_queue_deq_i && mq.size() > 0) begin
      void'(mq.pop_front());
      if (rd > 0) rd--;
      cabs++;
    end
    if (fe_queue_clr_i) begin
      mq.delete();
      rd = 0;
    end else begin
      if (fe_queue_roll_i) rd = 0;
      else if (fe_queue_yumi_i) rd++;
      if (enq) mq.push_back(fe_queue_i);
    end
  endtask

  // Compare at negedge, advance model at posedge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      model_compare();
      @(posedge clk);
      if (!rst_n) model_clear();
      else model_update();
    end
  end

  task automatic idle_inputs();
    fe_queue_v_i    = 1'b0;
    fe_queue_i      = '0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                      input logic dq, input logic rl, input logic cl);
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    fe_queue_deq_i  = dq;
    fe_queue_roll_i = rl;
    fe_queue_clr_i  = cl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  logic [7:0] exp_iss [8];

  initial begin
    exp_iss = '{8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB0, 8'hB1, 8'hB2};
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", W'(fe_queue_v_o), W'(0));
    chk("rst_occ", W'(occupancy_o), W'(0));
    chk("rst_ready", W'(fe_queue_ready_o), W'(1));
    rst_n = 1'b1;
    step(0, '0, 0, 0, 0, 0);

    // Fill to full
    for (int i = 0; i < 8; i++) step(1, W'(8'hA0 + i), 0, 0, 0, 0);
    chk("full_ready", W'(fe_queue_ready_o), W'(0));
    chk("full_occ", W'(occupancy_o), W'(8));
    chk("full_valid", W'(fe_queue_v_o), W'(1));
    chk("full_data", fe_queue_o, W'(8'hA0));
    step(1, W'(8'hFF), 0, 0, 0, 0);
    chk("ninth_occ", W'(occupancy_o), W'(8));

    // Issue three, commit three, refill across the wrap
    for (int i = 0; i < 3; i++) begin
      chk("iss_head", fe_queue_o, W'(8'hA0 + i));
      step(0, '0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, W'(8'hB0 + i), 0, 0, 0, 0);
    chk("wrap_bit", W'(dut.wptr_q[3]), W'(1));
    for (int i = 0; i < 8; i++) begin
      chk("iss_order", fe_queue_o, W'(exp_iss[i]));
      step(0, '0, 1, 0, 0, 0);
    end
    chk("drained_valid", W'(fe_queue_v_o), W'(0));
    for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 0, 0);
    chk("drained_occ", W'(occupancy_o), W'(0));

    // Roll back to the commit point
    for (int i = 0; i < 4; i++) step(1, W'(8'h10 + i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    chk("roll_data", fe_queue_o, W'(8'h11));
    chk("roll_valid", W'(fe_queue_v_o), W'(1));
    chk("roll_occ", W'(occupancy_o), W'(3));

    // Clr together with deq and an enqueue attempt
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, W'(8'h20 + i), 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    chk("pre_clr_occ", W'(occupancy_o), W'(6));
    fe_queue_clr_i = 1'b1;
    fe_queue_deq_i = 1'b1;
    fe_queue_v_i   = 1'b1;
    fe_queue_i     = W'(8'h99);
    #1;
    chk("clr_ready", W'(fe_queue_ready_o), W'(0));
    @(posedge clk);
    #1;
    idle_inputs();
    chk("clr_valid", W'(fe_queue_v_o), W'(0));
    chk("clr_occ", W'(occupancy_o), W'(0));

    // Roll + enqueue + yumi in one cycle
    for (int i = 0; i < 3; i++) step(1, W'(8'h30 + i), 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, '0, 1, 0, 0, 0);
    step(1, W'(8'h33), 1, 0, 1, 0);
    chk("rey_data", fe_queue_o, W'(8'h30));
    chk("rey_valid", W'(fe_queue_v_o), W'(1));
    chk("rey_occ", W'(occupancy_o), W'(4));

    // Async reset between edges
    step(1, W'(8'h34), 0, 0, 0, 0);
    chk("pre_rst_occ", W'(occupancy_o), W'(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(fe_queue_v_o), W'(0));
    chk("arst_occ", W'(occupancy_o), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, W'(8'h40), 0, 0, 0, 0);
    chk("post_rst_data", fe_queue_o, W'(8'h40));
    chk("post_rst_valid", W'(fe_queue_v_o), W'(1));
    chk("post_rst_wptr", W'(dut.wptr_q), W'(1));
    repeat (3) step(0, '0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
